// File: rtl/alu_shift_datapath_if.sv
// Operand/control/result bundle for alu_shift_datapath.
// The master drives operands and control and the slave returns the registered result.
interface alu_shift_datapath_if;
    logic [8:0] A;
    logic [8:0] B;
    logic [8:0] ctrl_bus;
    logic [8:0] Q;

    modport master (
        output A,
        output B,
        output ctrl_bus,
        input  Q
    );

    modport slave (
        input  A,
        input  B,
        input  ctrl_bus,
        output Q
    );
endinterface

// File: rtl/alu_shift_datapath.sv
// 9-bit mux -> ALU -> shifter datapath with feedback register R and result register Q.
// Optional shifter stage is built only when the SHIFTER_EN macro is defined.
module alu_shift_datapath (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_shift_datapath_if.slave  bus
);
    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_OR     = 3'b100;
    localparam logic [2:0] OP_XOR    = 3'b101;
    localparam logic [2:0] OP_NOT_A  = 3'b110;
    localparam logic [2:0] OP_PASS_M = 3'b111;

    logic [2:0] alu_op;
    logic       mux_sel;
    logic       r_clear;
    logic       q_clear;
    logic [8:0] mux_m;
    logic [8:0] alu_x;
    logic [8:0] shift_s;
    logic [8:0] r_reg;
    logic [8:0] q_reg;

    assign alu_op  = bus.ctrl_bus[2:0];
    assign mux_sel = bus.ctrl_bus[3];
    assign r_clear = bus.ctrl_bus[6];
    assign q_clear = bus.ctrl_bus[7];

    // R is the registered value from before this edge, so feedback never loops combinationally.
    assign mux_m = mux_sel ? r_reg : bus.B;

    always_comb begin
        alu_x = bus.A;
        case (alu_op)
            OP_PASS_A: alu_x = bus.A;
            OP_ADD:    alu_x = bus.A + mux_m;
            OP_SUB:    alu_x = bus.A - mux_m;
            OP_AND:    alu_x = bus.A & mux_m;
            OP_OR:     alu_x = bus.A | mux_m;
            OP_XOR:    alu_x = bus.A ^ mux_m;
            OP_NOT_A:  alu_x = ~bus.A;
            OP_PASS_M: alu_x = mux_m;
            default:   alu_x = bus.A;
        endcase
    end

`ifdef SHIFTER_EN
    logic [1:0] shift_op;
    logic [8:0] shl_x;
    logic [8:0] shr_x;
    logic [8:0] ror_x;
    logic       unused_ctrl;

    assign shift_op    = bus.ctrl_bus[5:4];
    assign unused_ctrl = bus.ctrl_bus[8];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi = gi + 1) begin : g_shift_bit
            if (gi == 0) begin : g_lsb
                assign shl_x[gi] = 1'b0;
            end else begin : g_lsb_n
                assign shl_x[gi] = alu_x[gi-1];
            end
            if (gi == 8) begin : g_msb
                assign shr_x[gi] = 1'b0;
                assign ror_x[gi] = alu_x[0];
            end else begin : g_msb_n
                assign shr_x[gi] = alu_x[gi+1];
                assign ror_x[gi] = alu_x[gi+1];
            end
        end
    endgenerate

    always_comb begin
        shift_s = alu_x;
        case (shift_op)
            2'b00:   shift_s = alu_x;
            2'b01:   shift_s = shl_x;
            2'b10:   shift_s = shr_x;
            2'b11:   shift_s = ror_x;
            default: shift_s = alu_x;
        endcase
    end
`else
    logic [2:0] unused_ctrl;

    // Shift field is don't-care when no shifter is built.
    assign unused_ctrl = {bus.ctrl_bus[8], bus.ctrl_bus[5:4]};
    assign shift_s     = alu_x;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= 9'd0;
            q_reg <= 9'd0;
        end else begin
            r_reg <= r_clear ? 9'd0 : shift_s;
            q_reg <= q_clear ? 9'd0 : shift_s;
        end
    end

    assign bus.Q = q_reg;
endmodule

// File: tb/tb_alu_shift_datapath.sv
// Directed and random stimulus for alu_shift_datapath with a queue-based scoreboard.
// Expected Q/R come from an independent behavioural model, honouring SHIFTER_EN.
module tb_alu_shift_datapath;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [8:0] model_r;
    logic [8:0] exp_q_queue[$];
    logic [8:0] exp_r_queue[$];

    alu_shift_datapath_if ifc ();

    alu_shift_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model_s(input logic [8:0] ctrl, input logic [8:0] a,
                                           input logic [8:0] m);
        logic [9:0] wide;
        logic [8:0] x;
        logic [8:0] s;
        case (ctrl[2:0])
            3'd0: x = a;
            3'd1: begin wide = {1'b0, a} + {1'b0, m}; x = wide[8:0]; end
            3'd2: begin wide = {1'b0, a} + 10'd512 - {1'b0, m}; x = wide[8:0]; end
            3'd3: x = a & m;
            3'd4: x = a | m;
            3'd5: x = a ^ m;
            3'd6: x = 9'h1FF ^ a;
            default: x = m;
        endcase
        s = x;
`ifdef SHIFTER_EN
        case (ctrl[5:4])
            2'd1: s = {x[7:0], 1'b0};
            2'd2: s = {1'b0, x[8:1]};
            2'd3: s = {x[0], x[8:1]};
            default: s = x;
        endcase
`endif
        return s;
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [8:0] ctrl, input logic [8:0] a, input logic [8:0] b);
        logic [8:0] m;
        logic [8:0] s;
        logic [8:0] eq;
        logic [8:0] er;
        @(negedge clk);
        ifc.ctrl_bus = ctrl;
        ifc.A        = a;
        ifc.B        = b;
        m = ctrl[3] ? model_r : b;
        s = model_s(ctrl, a, m);
        exp_q_queue.push_back(ctrl[7] ? 9'd0 : s);
        exp_r_queue.push_back(ctrl[6] ? 9'd0 : s);
        model_r = ctrl[6] ? 9'd0 : s;
        @(posedge clk);
        #1;
        eq = exp_q_queue.pop_front();
        er = exp_r_queue.pop_front();
        $display("txn ctrl=%03h A=%0d B=%0d -> Q=%0d (exp %0d) R=%0d (exp %0d)",
                 ctrl, a, b, ifc.Q, eq, dut.r_reg, er);
        check("q", ifc.Q, eq);
        check("r", dut.r_reg, er);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model_r = 9'd0;
        rst_n   = 1'b0;
        ifc.A = 9'd0; ifc.B = 9'd0; ifc.ctrl_bus = 9'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", ifc.Q, 9'd0);
        check("reset_r", dut.r_reg, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(9'h001, 9'd8, 9'd5);

        // Mid-cycle reset clears at once and holds across an edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q", ifc.Q, 9'd0);
        check("async_r", dut.r_reg, 9'd0);
        ifc.ctrl_bus = 9'h001; ifc.A = 9'd8; ifc.B = 9'd5;
        @(posedge clk);
        #1;
        check("hold_q", ifc.Q, 9'd0);
        check("hold_r", dut.r_reg, 9'd0);
        model_r = 9'd0;
        @(negedge clk);
        rst_n = 1'b1;

        step(9'h0C0, 9'd8, 9'd5);
        step(9'h000, 9'd8, 9'd0);
        step(9'h001, 9'd8, 9'd5);
        step(9'h009, 9'd1, 9'd0);
        step(9'h001, 9'd511, 9'd1);
        step(9'h002, 9'd0, 9'd1);
        step(9'h010, 9'd3, 9'd0);
        step(9'h020, 9'd3, 9'd0);
        step(9'h030, 9'd3, 9'd0);
        step(9'h030, 9'd256, 9'd0);
        step(9'h081, 9'd2, 9'd3);
        step(9'h041, 9'd2, 9'd3);
        step(9'h101, 9'd2, 9'd3);
        step(9'h001, 9'd2, 9'd3);
        step(9'h00A, 9'd7, 9'd0);
        step(9'h00F, 9'd0, 9'd0);
        step(9'h006, 9'h0AA, 9'd0);

        for (int i = 0; i < 24; i++) begin
            step(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                 9'($urandom_range(0, 511)));
        end

        if (exp_q_queue.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q_queue.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
